serial_comparator_lsb: RTL and testbench

- Bit-serial magnitude comparator that consumes operand bits LSB-first.
- It is the opposite-direction counterpart of the MSB-first iterative comparator chain.
  - MSB-first: the first difference found wins.
  - LSB-first: each later (more significant) difference overrides earlier ones.
- Used where operands arrive from a shift register LSB-first. Supports unsigned and two's-complement comparison, with a start/valid/done handshake.

---
 rtl/serial_comparator_lsb.sv | 118 +++++++++++
 tb/tb_serial_comparator_lsb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_comparator_lsb.sv
// LSB-first bit-serial magnitude comparator, unsigned or two's-complement.
// A later (more significant) bit difference overrides any earlier one.
module serial_comparator_lsb #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     signed_mode,
    input  logic                     bit_valid,
    input  logic                     a_bit,
    input  logic                     b_bit,
    output logic                     busy,
    output logic                     done,
    output logic                     gt,
    output logic                     lt,
    output logic                     eq,
    output logic [$clog2(WIDTH)-1:0] bit_count
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_p;
    logic          r_q;
    logic          r_signed;
    logic          r_gt;
    logic          r_lt;
    logic          r_eq;

    logic w_last;
    logic w_take;
    logic w_ea;
    logic w_eb;
    logic w_diff;
    logic w_p_nx;
    logic w_q_nx;

    assign w_last = (r_cnt == LAST);
    assign w_take = (r_state == S_RUN) && bit_valid && !start;

    // On the sign bit of a signed compare a 1 means smaller, so the operand roles swap.
    assign w_ea   = (w_last && r_signed) ? b_bit : a_bit;
    assign w_eb   = (w_last && r_signed) ? a_bit : b_bit;
    assign w_diff = w_ea ^ w_eb;
    assign w_p_nx = w_diff ? w_ea : r_p;
    assign w_q_nx = w_diff ? w_eb : r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                if (start)                w_next = S_RUN;
                else if (w_take && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_RUN);
        done      = (r_state == S_DONE);
        gt        = r_gt;
        lt        = r_lt;
        eq        = r_eq;
        bit_count = r_cnt;
    end

    // Start wins over any bit presented in the same cycle, in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_p      <= 1'b0;
            r_q      <= 1'b0;
            r_signed <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
        end else if (start) begin
            r_cnt    <= '0;
            r_p      <= 1'b0;
            r_q      <= 1'b0;
            r_signed <= signed_mode;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
        end else if (w_take) begin
            r_p <= w_p_nx;
            r_q <= w_q_nx;
            if (w_last) begin
                r_cnt <= '0;
                r_gt  <= w_p_nx;
                r_lt  <= w_q_nx;
                r_eq  <= ~w_p_nx & ~w_q_nx;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_serial_comparator_lsb.sv
// Bench for serial_comparator_lsb at WIDTH=4: directed scenarios plus randomized
// compares checked against an arithmetic reference model.
module tb_serial_comparator_lsb;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic         bit_valid = 1'b0;
    logic         a_bit = 1'b0;
    logic         b_bit = 1'b0;
    logic         busy;
    logic         done;
    logic         gt;
    logic         lt;
    logic         eq;
    logic [1:0]   bit_count;

    int compared   = 0;
    int mismatched = 0;

    serial_comparator_lsb #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit),
        .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq),
        .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-operand compare with plain arithmetic, returns {gt,lt,eq}.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sm);
        int ia;
        int ib;
        ia = sm ? int'($signed(a)) : int'(a);
        ib = sm ? int'($signed(b)) : int'(b);
        if (ia > ib)      return 3'b100;
        else if (ia < ib) return 3'b010;
        else              return 3'b001;
    endfunction

    // Apply inputs, let one rising edge pass, return 1 time unit after it.
    task automatic cyc(input logic s, input logic sm, input logic v, input logic a, input logic b);
        start = s; signed_mode = sm; bit_valid = v; a_bit = a; b_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic start_cycle(input logic sm);
        cyc(1'b1, sm, 1'($urandom), 1'($urandom), 1'($urandom));
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_cnt", bit_count, 0);
        chk("start_clr", {gt, lt, eq}, 3'b000);
    endtask

    // Feed all W bits LSB-first, optionally with idle gaps before bit gidx; ends in done cycle.
    task automatic run_bits(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                            input int gidx, input int gaps);
        logic [2:0] e;
        e = model(a, b, sm);
        for (int i = 0; i < W; i++) begin
            if (i == gidx) begin
                for (int g = 0; g < gaps; g++) begin
                    cyc(1'b0, 1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
                    chk("gap_cnt", bit_count, i);
                    chk("gap_busy", busy, 1);
                    chk("gap_done", done, 0);
                end
            end
            cyc(1'b0, 1'($urandom), 1'b1, a[i], b[i]);
            if (i < W - 1) begin
                chk("run_cnt", bit_count, i + 1);
                chk("run_busy", busy, 1);
                chk("run_done", done, 0);
            end else begin
                chk("fin_done", done, 1);
                chk("fin_busy", busy, 0);
                chk("fin_cnt", bit_count, 0);
                chk("fin_res", {gt, lt, eq}, e);
            end
        end
    endtask

    task automatic idle_hold(input int n, input logic [2:0] e);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("hold_done", done, 0);
            chk("hold_busy", busy, 0);
            chk("hold_res", {gt, lt, eq}, e);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        // Reset state
        #1;
        chk("rst_out", {busy, done, gt, lt, eq}, 5'b00000);
        chk("rst_cnt", bit_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("idle_ignore", {busy, done, gt, lt, eq, bit_count}, 7'b0000000);

        // Unsigned 10 vs 6
        start_cycle(1'b0);
        run_bits(4'b1010, 4'b0110, 1'b0, -1, 0);
        chk("u10v6_gt", gt, 1);
        idle_hold(1, 3'b100);

        // Signed -6 vs 6, then -1 vs -2
        start_cycle(1'b1);
        run_bits(4'b1010, 4'b0110, 1'b1, -1, 0);
        chk("s_m6v6_lt", lt, 1);
        idle_hold(1, 3'b010);
        start_cycle(1'b1);
        run_bits(4'b1111, 4'b1110, 1'b1, -1, 0);
        chk("s_m1vm2_gt", gt, 1);
        idle_hold(1, 3'b100);

        // Equal operands, 3 gap cycles between bits 1 and 2, then 10 idle cycles
        start_cycle(1'b0);
        run_bits(4'b0101, 4'b0101, 1'b0, 2, 3);
        idle_hold(10, 3'b001);

        // Restart with a bit presented on the restart cycle
        start_cycle(1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rs_done0", done, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rs_done1", done, 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rs_cnt", bit_count, 0);
        chk("rs_state", {busy, done, gt, lt, eq}, 5'b10000);
        run_bits(4'b0000, 4'b0001, 1'b0, -1, 0);
        chk("rs_lt", lt, 1);
        idle_hold(2, 3'b010);

        // Asynchronous reset after 2 bits, away from the clock edge
        start_cycle(1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out", {busy, done, gt, lt, eq}, 5'b00000);
        chk("arst_cnt", bit_count, 0);
        @(posedge clk);
        #1;
        chk("arst_hold", {busy, done, bit_count}, 4'b0000);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("arst_nodone", done, 0);
        start_cycle(1'b0);
        run_bits(4'b1001, 4'b0111, 1'b0, -1, 0);
        idle_hold(1, 3'b100);

        // Back-to-back: start in the DONE cycle
        start_cycle(1'b1);
        run_bits(4'b0001, 4'b1111, 1'b1, -1, 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("b2b_done", done, 0);
        chk("b2b_busy", busy, 1);
        chk("b2b_clr", {gt, lt, eq}, 3'b000);
        run_bits(4'b0011, 4'b0011, 1'b0, -1, 0);
        idle_hold(1, 3'b001);

        // Randomized compares with random mode and gaps
        for (int n = 0; n < 40; n++) begin
            ra = 4'($urandom);
            rb = (n % 5 == 0) ? ra : 4'($urandom);
            rs = 1'($urandom);
            start_cycle(rs);
            run_bits(ra, rb, rs, int'($urandom_range(0, W - 1)), int'($urandom_range(0, 2)));
            idle_hold(int'($urandom_range(1, 2)), model(ra, rb, rs));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
